// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter sharing one bank of WIDTH toggle flip-flops among
// NREQ requesters. A grant applies the winner's toggle mask to the bank for
// exactly one edge, then the FSM spends one ACK cycle before it re-arbitrates.
module tff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   tmask,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qn,
  output logic                    busy,
  output logic [CNTW-1:0]         gcnt
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE, ACK} state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic [PW-1:0]     idx;
  logic [PW-1:0]     ptr_nxt;
  logic              found;
  logic [WIDTH-1:0]  win_mask;
  logic [NREQ-1:0]   gnt_nxt;

  // Rotating priority search starting at ptr, plus the winner's mask and one-hot grant
  always_comb begin
    win      = '0;
    idx      = '0;
    found    = 1'b0;
    win_mask = '0;
    gnt_nxt  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) begin
        win_mask   = tmask[i*WIDTH +: WIDTH];
        gnt_nxt[i] = found;
      end
    end
    ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  // Two-state grant FSM; the bank toggles on the same edge that raises gnt
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      q     <= '0;
      ptr   <= '0;
      gcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= gnt_nxt;
            q     <= q ^ win_mask;
            ptr   <= ptr_nxt;
            gcnt  <= gcnt + 1'b1;
            state <= ACK;
          end else begin
            gnt <= '0;
          end
        end
        ACK: begin
          gnt   <= '0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ACK);
  assign qn   = ~q;

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Bench for tff_bank_arbiter: directed scenarios with hand-computed literals
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the grant/toggle rules.
module tb_tff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNTW  = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] tmask;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qn;
  logic                  busy;
  logic [CNTW-1:0]       gcnt;

  tff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req(req), .tmask(tmask),
    .gnt(gnt), .q(q), .qn(qn), .busy(busy), .gcnt(gcnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a grant may only happen if the previous edge did not grant
  bit        armed = 0;
  int        m_q, m_ptr, m_gcnt, m_gnt;
  bit        m_ack;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      armed  = 1;
      m_q    = 0;
      m_ptr  = 0;
      m_gcnt = 0;
      m_gnt  = 0;
      m_ack  = 0;
    end else if (armed) begin
      if (m_ack) begin
        m_ack = 0;
        m_gnt = 0;
      end else if (req != 0) begin
        int w;
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        m_gnt  = 1 << w;
        m_q    = m_q ^ int'(tmask[w*WIDTH +: WIDTH]);
        m_ptr  = (w + 1) % NREQ;
        m_gcnt = (m_gcnt + 1) % (1 << CNTW);
        m_ack  = 1;
      end else begin
        m_gnt = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      chk("gnt",  32'(gnt),  32'(m_gnt));
      chk("q",    32'(q),    32'(m_q));
      chk("qn",   32'(qn),   32'((~m_q) & ((1 << WIDTH) - 1)));
      chk("busy", 32'(busy), 32'(m_ack));
      chk("gcnt", 32'(gcnt), 32'(m_gcnt));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  int seq[$];
  int ng;

  initial begin
    rst   = 1'b1;
    req   = NREQ'($urandom);
    tmask = {$urandom, $urandom} & {(NREQ*WIDTH){1'b1}};
    cyc();
    cyc();
    chk("rst_q",    32'(q),    32'h00);
    chk("rst_qn",   32'(qn),   32'hFF);
    chk("rst_gnt",  32'(gnt),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gcnt", 32'(gcnt), 32'h0);
    rst = 1'b0;
    req = '0;

    // Single requester
    tmask[7:0] = 8'h0F;
    req = 4'b0001;
    cyc();
    chk("single_gnt",  32'(gnt),  32'h1);
    chk("single_q",    32'(q),    32'h0F);
    chk("single_busy", 32'(busy), 32'h1);
    req = '0;
    cyc();
    chk("single_gnt0",  32'(gnt),  32'h0);
    chk("single_busy0", 32'(busy), 32'h0);
    req = 4'b0001;
    cyc();
    req = '0;
    cyc();
    chk("single_q2",    32'(q),    32'h00);
    chk("single_gcnt2", 32'(gcnt), 32'h2);

    // Contention from reset
    do_reset();
    tmask = 32'h08040201;
    req   = 4'b1111;
    seq.delete();
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (gnt != 0) begin
        seq.push_back(int'(gnt));
        req = req & ~gnt;
      end
    end
    chk("cont_ngrants", 32'(seq.size()), 32'd4);
    for (int i = 0; i < 4 && i < seq.size(); i++)
      chk("cont_seq", 32'(seq[i]), 32'(1 << i));
    chk("cont_q",    32'(q),    32'h0F);
    chk("cont_gcnt", 32'(gcnt), 32'h4);

    // Fairness: req0 and req2 held continuously
    do_reset();
    tmask = {$urandom} & 32'h00FF00FF;
    req   = 4'b0101;
    seq.delete();
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (gnt != 0) seq.push_back(int'(gnt));
    end
    req = '0;
    cyc();
    chk("fair_ngrants", 32'(seq.size()), 32'd6);
    for (int i = 0; i < seq.size(); i++)
      chk("fair_seq", 32'(seq[i]), (i % 2 == 0) ? 32'h1 : 32'h4);

    // Reset in the ACK cycle of a grant
    do_reset();
    tmask = 32'h000000AA;
    req   = 4'b0001;
    cyc();
    chk("mid_q_pre", 32'(q), 32'hAA);
    req = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_gnt",  32'(gnt),  32'h0);
    chk("mid_q",    32'(q),    32'h00);
    chk("mid_busy", 32'(busy), 32'h0);
    req = 4'b0011;
    cyc();
    chk("mid_first", 32'(gnt), 32'h1);
    req = '0;
    cyc();

    // Pointer at 3 with req=1001
    do_reset();
    req = 4'b0100;
    cyc();
    req = '0;
    cyc();
    req = 4'b1001;
    cyc();
    chk("ptr3_win", 32'(gnt), 32'h8);
    req = 4'b0001;
    cyc();
    cyc();
    chk("ptr0_win", 32'(gnt), 32'h1);
    req = '0;
    cyc();

    // 256 grants: one 0x5A toggle then 255 zero-mask grants
    do_reset();
    tmask = 32'h0000005A;
    req   = 4'b0001;
    cyc();
    req = '0;
    cyc();
    tmask = '0;
    req   = 4'b0001;
    ng    = 0;
    for (int c = 0; c < 508; c++) begin
      cyc();
      if (gnt != 0) ng++;
    end
    chk("wrap_ngrants", 32'(ng),   32'd254);
    chk("wrap_gcnt255", 32'(gcnt), 32'd255);
    cyc();
    chk("wrap_gnt",  32'(gnt),  32'h1);
    chk("wrap_gcnt", 32'(gcnt), 32'h0);
    chk("wrap_q",    32'(q),    32'h5A);
    req = '0;
    cyc();

    // Randomized traffic honouring the handshake
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(7) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            tmask[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            req[i] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end
      end
      rst = ($urandom_range(99) == 0);
      cyc();
    end
    rst = 1'b0;
    req = '0;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
